mouse_cmd_arbiter: RTL
======================

MOUSE_CMD_ARBITER -- requirements
Module: mouse_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000: max cycles from SEND_BYTE pulse to acknowledge before abort.
REQ-002 Parameter MAX_RETRY, default 3: max re-sends after 0xFE or receive error.
REQ-003 Reset is RESET, synchronous, active-high; clock is CLK.
REQ-004 The ports SHALL be:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- REQ  in  2  per-requester command request, level
- BYTE0  in  8  command byte, requester 0
- BYTE1  in  8  command byte, requester 1
- GNT  out  2  one-hot grant, held for whole transaction
- DONE  out  1  one-cycle completion pulse
- ERR_CODE  out  2  valid with DONE: 00 ack, 01 retries exhausted, 10 timeout, 11 mouse error 0xFC
- BUSY  out  1  high whenever state is not IDLE
- SEND_BYTE  out  1  one-cycle pulse to transmitter
- BYTE_TO_SEND  out  8  byte to transmitter
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  receiver byte
- BYTE_ERROR_CODE  in  2  receiver error, 00 = ok
- BYTE_READY  in  1  receiver byte-valid pulse

Function
REQ-005 States SHALL be IDLE, SEND, WAIT_SENT, WAIT_ACK, DONE; all outputs registered.
REQ-006 IDLE: if any REQ bit set at edge k, grant SHALL be chosen round-robin (requester not granted last wins a tie; after reset, requester 0 wins), GNT set, BYTE_TO_SEND loaded from that requester's byte, retry count and timeout counter cleared, next state SEND.
REQ-007 SEND SHALL last exactly one cycle with SEND_BYTE=1, then go to WAIT_SENT.
REQ-008 WAIT_SENT: BYTE_SENT SHALL move to WAIT_ACK.
REQ-009 READ_ENABLE SHALL be 1 in SEND, WAIT_SENT, WAIT_ACK; 0 otherwise.
REQ-010 WAIT_ACK, on BYTE_READY with BYTE_ERROR_CODE=00:
- 0xFA -> DONE, ERR_CODE=00
- 0xFC -> DONE, ERR_CODE=11
- 0xFE -> retry
- any other value -> ignored, stay
REQ-011 BYTE_READY with BYTE_ERROR_CODE!=00 in WAIT_ACK SHALL be treated as 0xFE.
REQ-012 Retry: if retry count < MAX_RETRY, increment it, clear timeout counter, go to SEND (same byte); otherwise DONE with ERR_CODE=01.
REQ-013 Timeout counter SHALL increment every cycle in WAIT_SENT and WAIT_ACK; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to DONE with ERR_CODE=10, overriding any same-cycle BYTE_SENT/BYTE_READY.
REQ-014 DONE SHALL last one cycle with DONE=1 and GNT still asserted, then clear GNT, record last-granted requester, return to IDLE.
REQ-015 Earliest next grant SHALL be the cycle after DONE returns to IDLE (no back-to-back grant in DONE).
REQ-016 REQ deassertion or BYTEn change after grant SHALL NOT affect the transaction in progress.
REQ-017 BYTE_READY in IDLE, SEND or WAIT_SENT SHALL be ignored.
REQ-018 Retry count width SHALL hold MAX_RETRY; timeout counter width SHALL hold TIMEOUT_CYCLES.

Reset
REQ-019 RESET SHALL force IDLE, GNT=00, DONE=0, ERR_CODE=00, BUSY=0, SEND_BYTE=0, BYTE_TO_SEND=0x00, READ_ENABLE=0, counters 0, last-granted = requester 1.
REQ-020 RESET mid-transaction SHALL abort without DONE pulse; subsequent transmitter/receiver pulses SHALL be ignored in IDLE.

Verification
REQ-021 REQ=01, BYTE0=0xF4; BYTE_SENT, then BYTE_READY 0xFA -> GNT=01, one SEND_BYTE with 0xF4, DONE with ERR_CODE=00.
REQ-022 REQ=11 held over two transactions -> grants 01 then 10; REQ=11 after reset -> 01 first.
REQ-023 Four 0xFE replies, MAX_RETRY=3 -> 4 SEND_BYTE pulses total, DONE ERR_CODE=01.
REQ-024 TIMEOUT_CYCLES=100, no BYTE_SENT -> DONE ERR_CODE=10 exactly 100 cycles after SEND cycle.
REQ-025 BYTE_READY 0x08 then 0xFC -> 0x08 ignored, DONE ERR_CODE=11.
REQ-026 RESET asserted in WAIT_ACK -> all outputs at reset values next cycle, no DONE.

Source files
------------

// File: rtl/mouse_cmd_arbiter.sv
// Two-requester arbiter for PS/2 mouse commands: grants one requester, sends its
// byte, waits for the mouse reply, and retries or times out as needed.
module mouse_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ,
  input  logic [7:0] BYTE0,
  input  logic [7:0] BYTE1,
  output logic [1:0] GNT,
  output logic       DONE,
  output logic [1:0] ERR_CODE,
  output logic       BUSY,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  // The counter reaches TIMEOUT_CYCLES-1 on the edge where it currently holds
  // TIMEOUT_CYCLES-2, so DONE lands exactly TIMEOUT_CYCLES cycles after SEND.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t          state_r;
  logic [RW-1:0]   retry_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic            last_gnt_r;

  logic            pick_s;
  logic            ack_s;
  logic            fault_s;
  logic            resend_s;
  logic            tmo_hit_s;
  logic            retry_ok_s;

  // Round-robin choice: on a tie the requester not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end else if (req[0]) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

  assign pick_s     = rr_pick(REQ, last_gnt_r);
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
  assign retry_ok_s = (retry_cnt_r < RETRY_MAX);

  // Classify the received byte; a receiver error counts as a resend request.
  always_comb begin
    ack_s    = 1'b0;
    fault_s  = 1'b0;
    resend_s = 1'b0;
    if (BYTE_ERROR_CODE != 2'b00) begin
      resend_s = 1'b1;
    end else begin
      case (BYTE_READ)
        8'hFA:   ack_s    = 1'b1;
        8'hFC:   fault_s  = 1'b1;
        8'hFE:   resend_s = 1'b1;
        default: resend_s = 1'b0;
      endcase
    end
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      GNT          <= 2'b00;
      DONE         <= 1'b0;
      ERR_CODE     <= 2'b00;
      BUSY         <= 1'b0;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= 8'h00;
      READ_ENABLE  <= 1'b0;
      retry_cnt_r  <= '0;
      tmo_cnt_r    <= '0;
      last_gnt_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (REQ != 2'b00) begin
            state_r      <= ST_SEND;
            GNT          <= pick_s ? 2'b10 : 2'b01;
            BYTE_TO_SEND <= pick_s ? BYTE1 : BYTE0;
            retry_cnt_r  <= '0;
            tmo_cnt_r    <= '0;
            SEND_BYTE    <= 1'b1;
            READ_ENABLE  <= 1'b1;
            BUSY         <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SEND: begin
          state_r   <= ST_WAIT_SENT;
          SEND_BYTE <= 1'b0;
        end

        ST_WAIT_SENT: begin
          if (tmo_hit_s) begin
            state_r     <= ST_DONE;
            DONE        <= 1'b1;
            ERR_CODE    <= 2'b10;
            READ_ENABLE <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            if (BYTE_SENT) begin
              state_r <= ST_WAIT_ACK;
            end else begin
              state_r <= ST_WAIT_SENT;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (tmo_hit_s) begin
            state_r     <= ST_DONE;
            DONE        <= 1'b1;
            ERR_CODE    <= 2'b10;
            READ_ENABLE <= 1'b0;
          end else if (BYTE_READY && (ack_s || fault_s)) begin
            state_r     <= ST_DONE;
            DONE        <= 1'b1;
            ERR_CODE    <= ack_s ? 2'b00 : 2'b11;
            READ_ENABLE <= 1'b0;
          end else if (BYTE_READY && resend_s && retry_ok_s) begin
            // Resend the same latched byte with a fresh timeout window.
            state_r     <= ST_SEND;
            SEND_BYTE   <= 1'b1;
            retry_cnt_r <= retry_cnt_r + RW'(1);
            tmo_cnt_r   <= '0;
          end else if (BYTE_READY && resend_s) begin
            state_r     <= ST_DONE;
            DONE        <= 1'b1;
            ERR_CODE    <= 2'b01;
            READ_ENABLE <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            state_r   <= ST_WAIT_ACK;
          end
        end

        ST_DONE: begin
          state_r    <= ST_IDLE;
          DONE       <= 1'b0;
          GNT        <= 2'b00;
          BUSY       <= 1'b0;
          last_gnt_r <= GNT[1];
        end

        default: begin
          state_r     <= ST_IDLE;
          GNT         <= 2'b00;
          DONE        <= 1'b0;
          BUSY        <= 1'b0;
          SEND_BYTE   <= 1'b0;
          READ_ENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule
